// File: rtl/mux_pkg.sv
// Shared definitions for the registered N-channel multiplexer.
//   MODO_DIRETO / MODO_RR : values of the Modo input (direct select / round-robin scan)
//   estado_t              : output-register FSM state (VAZIO = empty, CHEIO = holding a word)
package mux_pkg;

    localparam logic MODO_DIRETO = 1'b0;
    localparam logic MODO_RR     = 1'b1;

    typedef enum logic {
        VAZIO = 1'b0,
        CHEIO = 1'b1
    } estado_t;

endpackage

// File: rtl/arbitro_rr.sv
// Combinational rotating-priority picker.
// Searches req starting at index ponteiro and wrapping modulo CANAIS; the first
// set bit wins.
//   req      in  CANAIS : request vector
//   ponteiro in  SEL    : index with highest priority (always < CANAIS)
//   grant    out CANAIS : one-hot grant, all zero when nothing requested
//   indice   out SEL    : index of the granted request (0 when none)
//   achou    out 1      : at least one request was found
module arbitro_rr #(
    parameter int CANAIS = 4,
    parameter int SEL    = $clog2(CANAIS)
) (
    input  logic [CANAIS-1:0] req,
    input  logic [SEL-1:0]    ponteiro,
    output logic [CANAIS-1:0] grant,
    output logic [SEL-1:0]    indice,
    output logic              achou
);

    // Rotate the request vector so the priority channel lands on bit 0;
    // a plain fixed-priority search over the rotated copy then gives the
    // rotating-priority result.
    logic [2*CANAIS-1:0] dobrado;
    logic [CANAIS-1:0]   girado;

    assign dobrado = {req, req} >> ponteiro;
    assign girado  = dobrado[CANAIS-1:0];

    always_comb begin
        int pos;
        achou = 1'b0;
        pos   = 0;
        for (int j = 0; j < CANAIS; j++) begin
            if (!achou && girado[j]) begin
                achou = 1'b1;
                pos   = int'(ponteiro) + j;
            end
        end
        // Undo the rotation: offset from the pointer back to an absolute index.
        if (pos >= CANAIS) begin
            pos = pos - CANAIS;
        end
        indice = SEL'(pos);

        grant = '0;
        for (int k = 0; k < CANAIS; k++) begin
            if (achou && (indice == SEL'(k))) begin
                grant[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_n_reg.sv
// Registered N-channel multiplexer with valid/ready output handshake.
// Selects one channel per capture, either directly (Controle) or by a
// round-robin scan, and holds it in an output register until consumed.
//   Clock           in  1               : rising-edge clock
//   Resetn          in  1               : asynchronous active-low reset
//   Entradas        in  CANAIS*LARGURA  : channel k at [k*LARGURA +: LARGURA]
//   EntradaValida   in  CANAIS          : per-channel valid
//   Aceito          out CANAIS          : one-hot, high in the cycle channel k is captured
//   Controle        in  SEL             : channel select in direct mode
//   Modo            in  1               : 0 = direct, 1 = round-robin
//   Pronto          in  1               : downstream ready
//   Resultado       out LARGURA         : registered selected data
//   ResultadoValido out 1               : Resultado holds an unconsumed word
//   CanalAtual      out SEL             : channel that produced Resultado
//
// state | meaning
// ------+----------------------------------------------
// VAZIO | output register empty, ResultadoValido = 0
// CHEIO | output register holds a word, ResultadoValido = 1
module mux_n_reg
    import mux_pkg::*;
#(
    parameter int LARGURA = 8,
    parameter int CANAIS  = 4,
    parameter int SEL     = $clog2(CANAIS)
) (
    input  logic                      Clock,
    input  logic                      Resetn,
    input  logic [CANAIS*LARGURA-1:0] Entradas,
    input  logic [CANAIS-1:0]         EntradaValida,
    output logic [CANAIS-1:0]         Aceito,
    input  logic [SEL-1:0]            Controle,
    input  logic                      Modo,
    input  logic                      Pronto,
    output logic [LARGURA-1:0]        Resultado,
    output logic                      ResultadoValido,
    output logic [SEL-1:0]            CanalAtual
);

    estado_t             estado_q, estado_d;
    logic [SEL-1:0]      ponteiro_q;
    logic [SEL-1:0]      ponteiro_prox;

    logic [CANAIS-1:0]   rr_grant;
    logic [SEL-1:0]      rr_indice;
    logic                rr_achou;

    logic [CANAIS-1:0]   dir_grant;
    logic                dir_achou;

    logic [CANAIS-1:0]   cand_grant;
    logic [SEL-1:0]      cand_indice;
    logic                cand_achou;

    logic                livre;
    logic                captura;
    logic [LARGURA-1:0]  dado_sel;

    arbitro_rr #(
        .CANAIS (CANAIS),
        .SEL    (SEL)
    ) u_arbitro (
        .req      (EntradaValida),
        .ponteiro (ponteiro_q),
        .grant    (rr_grant),
        .indice   (rr_indice),
        .achou    (rr_achou)
    );

    // Direct mode: comparing against every legal index also rejects any
    // Controle value >= CANAIS without an out-of-range bit select.
    always_comb begin
        dir_grant = '0;
        dir_achou = 1'b0;
        for (int k = 0; k < CANAIS; k++) begin
            if ((Controle == SEL'(k)) && EntradaValida[k]) begin
                dir_grant[k] = 1'b1;
                dir_achou    = 1'b1;
            end
        end
    end

    always_comb begin
        if (Modo == MODO_RR) begin
            cand_grant  = rr_grant;
            cand_indice = rr_indice;
            cand_achou  = rr_achou;
        end else begin
            cand_grant  = dir_grant;
            cand_indice = Controle;
            cand_achou  = dir_achou;
        end
    end

    assign livre   = (estado_q == VAZIO) || Pronto;
    // Gating with Resetn keeps Aceito low while reset is held, even though
    // the empty register would otherwise look free.
    assign captura = Resetn && livre && cand_achou;
    assign Aceito  = captura ? cand_grant : '0;

    always_comb begin
        dado_sel = '0;
        for (int k = 0; k < CANAIS; k++) begin
            if (cand_grant[k]) begin
                dado_sel = Entradas[k*LARGURA +: LARGURA];
            end
        end
    end

    assign ponteiro_prox = (cand_indice == SEL'(CANAIS - 1)) ? '0 : cand_indice + SEL'(1);

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            VAZIO: begin
                if (captura) begin
                    estado_d = CHEIO;
                end
            end
            CHEIO: begin
                if (Pronto && !captura) begin
                    estado_d = VAZIO;
                end
            end
            default: estado_d = VAZIO;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            estado_q <= VAZIO;
        end else begin
            estado_q <= estado_d;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            Resultado  <= '0;
            CanalAtual <= '0;
            ponteiro_q <= '0;
        end else if (captura) begin
            Resultado  <= dado_sel;
            CanalAtual <= cand_indice;
            // Direct-mode captures leave the scan position untouched.
            if (Modo == MODO_RR) begin
                ponteiro_q <= ponteiro_prox;
            end
        end
    end

    assign ResultadoValido = (estado_q == CHEIO);

endmodule

// File: tb/tb_mux_n_reg.sv
module tb_mux_n_reg;

    localparam int LARGURA = 8;
    localparam int CANAIS  = 4;
    localparam int SEL     = 2;

    logic                      Clock;
    logic                      Resetn;
    logic [CANAIS*LARGURA-1:0] Entradas;
    logic [CANAIS-1:0]         EntradaValida;
    logic [CANAIS-1:0]         Aceito;
    logic [SEL-1:0]            Controle;
    logic                      Modo;
    logic                      Pronto;
    logic [LARGURA-1:0]        Resultado;
    logic                      ResultadoValido;
    logic [SEL-1:0]            CanalAtual;

    int n_checks = 0;
    int n_errors = 0;

    mux_n_reg #(
        .LARGURA (LARGURA),
        .CANAIS  (CANAIS),
        .SEL     (SEL)
    ) dut (
        .Clock           (Clock),
        .Resetn          (Resetn),
        .Entradas        (Entradas),
        .EntradaValida   (EntradaValida),
        .Aceito          (Aceito),
        .Controle        (Controle),
        .Modo            (Modo),
        .Pronto          (Pronto),
        .Resultado       (Resultado),
        .ResultadoValido (ResultadoValido),
        .CanalAtual      (CanalAtual)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs are already applied; check Aceito before the edge, then the
    // registered outputs just after it.
    task automatic ciclo(input string tag, input logic [3:0] exp_ac, input logic [7:0] exp_res,
                         input logic exp_vld, input logic [1:0] exp_can);
        #1;
        chk({tag, " aceito"}, 32'(Aceito), 32'(exp_ac));
        @(posedge Clock);
        #1;
        chk({tag, " resultado"}, 32'(Resultado), 32'(exp_res));
        chk({tag, " valido"}, 32'(ResultadoValido), 32'(exp_vld));
        chk({tag, " canal"}, 32'(CanalAtual), 32'(exp_can));
    endtask

    initial begin
        Resetn        = 1'b0;
        Entradas      = 32'h44A5_2211;
        EntradaValida = 4'b1111;
        Controle      = 2'd2;
        Modo          = 1'b1;
        Pronto        = 1'b1;

        #2;
        chk("rst resultado", 32'(Resultado), 32'h0);
        chk("rst valido", 32'(ResultadoValido), 32'h0);
        chk("rst canal", 32'(CanalAtual), 32'h0);
        chk("rst aceito", 32'(Aceito), 32'h0);
        @(posedge Clock);
        #1;
        chk("rst edge resultado", 32'(Resultado), 32'h0);
        chk("rst edge aceito", 32'(Aceito), 32'h0);
        Resetn = 1'b1;

        // Direct mode
        Modo = 1'b0;
        ciclo("dir ch2", 4'b0100, 8'hA5, 1'b1, 2'd2);
        Controle = 2'd1;
        ciclo("dir ch1 b2b", 4'b0010, 8'h22, 1'b1, 2'd1);
        Controle = 2'd2;
        EntradaValida = 4'b1011;
        ciclo("dir invalid", 4'b0000, 8'h22, 1'b0, 2'd1);
        ciclo("dir idle", 4'b0000, 8'h22, 1'b0, 2'd1);

        // Round-robin, pointer starts at 0; first capture with Pronto low while empty
        Modo = 1'b1;
        EntradaValida = 4'b1111;
        Pronto = 1'b0;
        ciclo("rr 0", 4'b0001, 8'h11, 1'b1, 2'd0);
        Pronto = 1'b1;
        ciclo("rr 1", 4'b0010, 8'h22, 1'b1, 2'd1);
        ciclo("rr 2", 4'b0100, 8'hA5, 1'b1, 2'd2);
        ciclo("rr 3", 4'b1000, 8'h44, 1'b1, 2'd3);
        ciclo("rr 4", 4'b0001, 8'h11, 1'b1, 2'd0);
        ciclo("rr 5", 4'b0010, 8'h22, 1'b1, 2'd1);

        // Pointer is 2: only ch0 valid -> ch0, pointer becomes 1
        EntradaValida = 4'b0001;
        ciclo("rr only0", 4'b0001, 8'h11, 1'b1, 2'd0);
        // Pointer 1 with 1001: ch3 then ch0 (wrap)
        EntradaValida = 4'b1001;
        ciclo("rr wrap ch3", 4'b1000, 8'h44, 1'b1, 2'd3);
        ciclo("rr wrap ch0", 4'b0001, 8'h11, 1'b1, 2'd0);
        // Direct capture must not move the pointer (still 1)
        Modo = 1'b0;
        Controle = 2'd3;
        EntradaValida = 4'b1111;
        ciclo("dir keep ptr", 4'b1000, 8'h44, 1'b1, 2'd3);
        Modo = 1'b1;
        ciclo("rr after dir", 4'b0010, 8'h22, 1'b1, 2'd1);

        // Hold with Pronto low while inputs and mode change
        Pronto = 1'b0;
        Entradas = 32'hDEAD_BEEF;
        Modo = 1'b0;
        Controle = 2'd0;
        ciclo("hold 1", 4'b0000, 8'h22, 1'b1, 2'd1);
        Entradas = 32'h0102_0304;
        Modo = 1'b1;
        ciclo("hold 2", 4'b0000, 8'h22, 1'b1, 2'd1);
        Entradas = 32'h5566_7788;
        EntradaValida = 4'b0101;
        ciclo("hold 3", 4'b0000, 8'h22, 1'b1, 2'd1);
        // Pointer is 2
        Pronto = 1'b1;
        EntradaValida = 4'b1111;
        ciclo("hold release", 4'b0100, 8'h66, 1'b1, 2'd2);

        // Reset pulse between edges while full (pointer is 3)
        Pronto = 1'b0;
        #2;
        Resetn = 1'b0;
        #1;
        chk("midrst resultado", 32'(Resultado), 32'h0);
        chk("midrst valido", 32'(ResultadoValido), 32'h0);
        chk("midrst canal", 32'(CanalAtual), 32'h0);
        chk("midrst aceito", 32'(Aceito), 32'h0);
        #1;
        Resetn = 1'b1;
        Pronto = 1'b1;
        ciclo("post rst ch0", 4'b0001, 8'h88, 1'b1, 2'd0);

        // Nothing valid: register drains, data holds
        EntradaValida = 4'b0000;
        ciclo("drain", 4'b0000, 8'h88, 1'b0, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
